alu_op_sequencer: RTL
=====================

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 Parameter DATA_W, 32, instruction register width in bits; minimum 24.
REQ-002 Parameter REG_AW, 4, register-address field width; register count = 2**REG_AW, maximum 16.
REQ-003 Parameter ALU_OP_W, 4, width of alu_op.
REQ-004 clk  in  1  sole clock; all state changes occur on its rising edge.
REQ-005 clr  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  request one fetch/execute sequence; sampled in IDLE and T5.
REQ-007 ir  in  DATA_W  instruction register contents; opcode ir[DATA_W-1:DATA_W-5], ra next REG_AW bits, rb next, rc next.
REQ-008 mem_ready  in  1  memory read data valid.
REQ-009 step  in  1  single-step advance pulse; used only under STEP_MODE_EN.
REQ-010 bus_sel  out  5  bus source code: 0..15 register, 19 Zlo, 20 PC, 21 MDR, 22 immediate C; 0 when idle.
REQ-011 load_sel  out  5  destination enable code: 0..15 register, 20 PC, 21 MDR, 23 IR, 24 Z, 25 MAR, 27 Y; 31 = none.
REQ-012 mem_read  out  1  MDR loads from memory.
REQ-013 pc_inc  out  1  PC increments this cycle.
REQ-014 alu_op  out  ALU_OP_W  ALU function: 1 ADD, 2 SUB, 3 AND, 4 OR; 0 otherwise.
REQ-015 busy, done, illegal  out  1 each  sequence active; final-cycle pulse; undefined-opcode flag.

Function
REQ-016 States SHALL be IDLE, T0, T1, T2, T3, T4, T5, TRAP, encoded as a registered FSM; all outputs SHALL be decoded from registered state and ir only.
REQ-017 IDLE: all outputs zero except load_sel=31; start=1 SHALL move to T0 on the next edge.
REQ-018 T0: bus_sel=20, load_sel=25, pc_inc=1; next T1.
REQ-019 T1: load_sel=21, mem_read=1; SHALL remain in T1 while mem_ready=0 and advance to T2 on the first edge with mem_ready=1.
REQ-020 T2: bus_sel=21, load_sel=23; next T3.
REQ-021 T3: decode opcode; opcode 00011/00100/00101/00110/01100 SHALL give bus_sel=rb, load_sel=27, next T4; any other opcode SHALL go to TRAP.
REQ-022 T4: load_sel=24; alu_op per opcode (00011 ADD, 00100 SUB, 00101 AND, 00110 OR, 01100 ADD); bus_sel=rc for register forms, 22 for 01100 (ADDI).
REQ-023 T5: bus_sel=19, load_sel=ra, done=1; start=1 SHALL go directly to T0 (back-to-back, no IDLE cycle), else IDLE.
REQ-024 TRAP: illegal=1, load_sel=31; SHALL hold until clr.
REQ-025 busy SHALL be 1 in T0..T5 and TRAP; done SHALL be exactly one cycle wide per completed sequence.
REQ-026 Register fields wider than REG_AW SHALL NOT be generated; bus_sel/load_sel register codes SHALL be zero-extended to 5 bits.
REQ-027 Execute latency SHALL be 6 cycles from T0 to T5 inclusive with mem_ready=1 in T1; each T1 wait cycle adds one.
REQ-028 start asserted outside IDLE/T5 SHALL be ignored.

Reset
REQ-029 clr=1 at a rising edge SHALL force IDLE in any state, including mid-sequence, T1 wait, and TRAP.
REQ-030 In the cycle after reset, outputs SHALL be IDLE values: bus_sel=0, load_sel=31, all 1-bit outputs 0, alu_op=0.
REQ-031 clr SHALL take priority over start, step and mem_ready in the same cycle.

Configuration
REQ-032 With macro STEP_MODE_EN defined, every transition out of T0..T5 SHALL additionally require step=1; T1 SHALL require step=1 and mem_ready=1 in the same cycle.
REQ-033 Without STEP_MODE_EN, the step port SHALL exist and be ignored; timing per REQ-017..023.

Verification
REQ-034 clr; ir=0x1A380000 (ADD ra=4, rb=7, rc=0); start pulse; mem_ready=1 -> T0..T5 in 6 cycles; T3 bus_sel=7; T4 bus_sel=0, alu_op=1; T5 load_sel=4, done=1 for one cycle.
REQ-035 Same ADD with mem_ready low for 3 cycles in T1 -> mem_read held 4 cycles; done 9 cycles after T0 entry.
REQ-036 ir opcode 01100 -> T4 bus_sel=22, alu_op=1; opcode 11111 -> TRAP, illegal=1 held until clr.
REQ-037 start held high across T5 -> next cycle is T0 with no IDLE; two done pulses 6 cycles apart.
REQ-038 clr asserted during T3 -> next cycle IDLE, load_sel=31, busy=0, done never asserted.
REQ-039 STEP_MODE_EN build, step pulsed every 4th cycle -> one state advance per step pulse; no advance without step.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Fetch/decode/execute control sequencer driving a single-bus ALU datapath.
// Define STEP_MODE_EN to gate every T0..T5 transition on the step input.
module alu_op_sequencer #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned REG_AW   = 4,
  parameter int unsigned ALU_OP_W = 4
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                start,
  input  logic [DATA_W-1:0]   ir,
  input  logic                mem_ready,
  input  logic                step,
  output logic [4:0]          bus_sel,
  output logic [4:0]          load_sel,
  output logic                mem_read,
  output logic                pc_inc,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                busy,
  output logic                done,
  output logic                illegal
);

  typedef enum logic [2:0] {
    StIdle, StT0, StT1, StT2, StT3, StT4, StT5, StTrap
  } state_e;

  state_e state_q, state_d;

  logic [4:0]          opcode;
  logic [REG_AW-1:0]   ra, rb, rc;
  logic                op_legal, op_imm;
  logic [ALU_OP_W-1:0] op_func;
  logic                adv;
  logic                unused_bits;

  assign opcode = ir[DATA_W-1 -: 5];
  assign ra     = ir[DATA_W-6 -: REG_AW];
  assign rb     = ir[DATA_W-6-REG_AW -: REG_AW];
  assign rc     = ir[DATA_W-6-2*REG_AW -: REG_AW];

  // Low ir bits below rc carry no control information.
  assign unused_bits = ^{ir, step};

`ifdef STEP_MODE_EN
  assign adv = step;
`else
  assign adv = 1'b1;
`endif

  always_comb begin
    op_legal = 1'b1;
    op_imm   = 1'b0;
    op_func  = '0;
    case (opcode)
      5'b00011: op_func = ALU_OP_W'(1);
      5'b00100: op_func = ALU_OP_W'(2);
      5'b00101: op_func = ALU_OP_W'(3);
      5'b00110: op_func = ALU_OP_W'(4);
      5'b01100: begin
        op_func = ALU_OP_W'(1);
        op_imm  = 1'b1;
      end
      default:  op_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StT0;
      StT0:    if (adv) state_d = StT1;
      StT1:    if (adv && mem_ready) state_d = StT2;
      StT2:    if (adv) state_d = StT3;
      StT3:    if (adv) state_d = op_legal ? StT4 : StTrap;
      StT4:    if (adv) state_d = StT5;
      StT5:    if (adv) state_d = start ? StT0 : StIdle;
      StTrap:  state_d = StTrap;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    bus_sel  = 5'd0;
    load_sel = 5'd31;
    mem_read = 1'b0;
    pc_inc   = 1'b0;
    alu_op   = '0;
    done     = 1'b0;
    illegal  = 1'b0;
    busy     = (state_q != StIdle);
    case (state_q)
      StT0: begin
        bus_sel  = 5'd20;
        load_sel = 5'd25;
        pc_inc   = 1'b1;
      end
      StT1: begin
        load_sel = 5'd21;
        mem_read = 1'b1;
      end
      StT2: begin
        bus_sel  = 5'd21;
        load_sel = 5'd23;
      end
      StT3: begin
        if (op_legal) begin
          bus_sel  = 5'(rb);
          load_sel = 5'd27;
        end
      end
      StT4: begin
        bus_sel  = op_imm ? 5'd22 : 5'(rc);
        load_sel = 5'd24;
        alu_op   = op_func;
      end
      StT5: begin
        bus_sel  = 5'd19;
        load_sel = 5'(ra);
        done     = 1'b1;
      end
      StTrap:  illegal = 1'b1;
      default: ;
    endcase
  end

endmodule
